// File: rtl/stream_arb_mux.sv
// stream_arb_mux: N:1 valid/ready multiplexer with a built-in arbiter
// (round-robin or fixed priority), an optional forced select, and a
// one-entry registered output stage that provides backpressure.
module stream_arb_mux #(
   parameter int unsigned N     = 4,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned MODE  = 0,
   parameter int unsigned SELW  = (N > 2) ? $clog2(N) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         in_valid,
   input  logic [N*WIDTH-1:0]   in_data,
   output logic [N-1:0]         in_ready,
   input  logic                 force_en,
   input  logic [SELW-1:0]      force_sel,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_sel,
   input  logic                 out_ready
);

   // One extra bit so ptr + k (< 2N) never overflows before the wrap.
   localparam int unsigned IW = SELW + 1;

   logic                out_valid_q, out_valid_d;
   logic [WIDTH-1:0]    out_data_q,  out_data_d;
   logic [SELW-1:0]     out_sel_q,   out_sel_d;
   logic [SELW-1:0]     ptr_q,       ptr_d;

   logic [N-1:0]        elig;
   logic [SELW-1:0]     base;
   logic [IW-1:0]       idx;
   logic                hit;
   logic [SELW-1:0]     grant;
   logic                grant_vld;
   logic [WIDTH-1:0]    grant_data;
   logic                load;
   logic                xfer;

   // Output slot can take a word when empty or being drained this cycle.
   assign load = ~out_valid_q | out_ready;

   // Eligible set: all valids, or only the forced channel (none if out of range).
   always_comb begin
      elig = '0;
      for (int i = 0; i < N; i++) begin
         if (force_en) elig[i] = in_valid[i] & (force_sel == SELW'(i));
         else          elig[i] = in_valid[i];
      end
   end

   // Search from ptr (round-robin) or from 0 (fixed priority), wrapping modulo N.
   always_comb begin
      base      = (MODE == 0) ? ptr_q : '0;
      grant     = '0;
      grant_vld = 1'b0;
      idx       = '0;
      hit       = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = {1'b0, base} + IW'(k);
         if (idx >= IW'(N)) idx = idx - IW'(N);
         hit = 1'b0;
         for (int j = 0; j < N; j++) begin
            if (idx == IW'(j)) hit = elig[j];
         end
         if (hit && !grant_vld) begin
            grant_vld = 1'b1;
            grant     = idx[SELW-1:0];
         end
      end
   end

   // Data of the granted channel and the one-hot ready back to it.
   always_comb begin
      grant_data = '0;
      in_ready   = '0;
      for (int i = 0; i < N; i++) begin
         if (grant == SELW'(i)) begin
            grant_data  = in_data[i*WIDTH +: WIDTH];
            in_ready[i] = rst_n & load & grant_vld;
         end
      end
   end

   assign xfer = rst_n & load & grant_vld;

   // Next-state for the output slot and the round-robin pointer.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      ptr_d       = ptr_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = grant_data;
         out_sel_d   = grant;
         if ((MODE == 0) && !force_en) begin
            ptr_d = (grant == SELW'(N - 1)) ? '0 : grant + SELW'(1);
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed bench for stream_arb_mux: three instances cover round-robin with a
// widened select, fixed priority, and a non-power-of-two channel count.
module tb_stream_arb_mux;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Instance A: N=4, round-robin, SELW=3 so force_sel=5 is expressible.
   logic [3:0]  a_valid, a_ready;
   logic [31:0] a_data;
   logic        a_fen, a_oval, a_ordy;
   logic [2:0]  a_fsel, a_osel;
   logic [7:0]  a_odata;

   // Instance B: N=4, fixed priority.
   logic [3:0]  b_valid, b_ready;
   logic [31:0] b_data;
   logic        b_oval, b_ordy;
   logic [1:0]  b_osel;
   logic [7:0]  b_odata;

   // Instance C: N=3, round-robin.
   logic [2:0]  c_valid, c_ready;
   logic [23:0] c_data;
   logic        c_oval, c_ordy;
   logic [1:0]  c_osel;
   logic [7:0]  c_odata;

   int total = 0;
   int bad   = 0;

   stream_arb_mux #(.N(4), .WIDTH(8), .MODE(0), .SELW(3)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_data(a_data),
      .in_ready(a_ready), .force_en(a_fen), .force_sel(a_fsel),
      .out_valid(a_oval), .out_data(a_odata), .out_sel(a_osel), .out_ready(a_ordy));

   stream_arb_mux #(.N(4), .WIDTH(8), .MODE(1)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_data(b_data),
      .in_ready(b_ready), .force_en(1'b0), .force_sel(2'd0),
      .out_valid(b_oval), .out_data(b_odata), .out_sel(b_osel), .out_ready(b_ordy));

   stream_arb_mux #(.N(3), .WIDTH(8), .MODE(0)) u_c (
      .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_data(c_data),
      .in_ready(c_ready), .force_en(1'b0), .force_sel(2'd0),
      .out_valid(c_oval), .out_data(c_odata), .out_sel(c_osel), .out_ready(c_ordy));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst_n   = 1'b0;
      a_valid = 4'b1111; a_data = 32'hA3A2A1A0; a_fen = 1'b0; a_fsel = 3'd0; a_ordy = 1'b1;
      b_valid = 4'b1111; b_data = 32'hB3B2B1B0; b_ordy = 1'b1;
      c_valid = 3'b111;  c_data = 24'hC2C1C0;   c_ordy = 1'b1;

      // Reset held for two edges with everything valid.
      tick();
      tick();
      check("rst_a_oval",  32'(a_oval),  32'h0);
      check("rst_a_odata", 32'(a_odata), 32'h00);
      check("rst_a_osel",  32'(a_osel),  32'h0);
      check("rst_a_ready", 32'(a_ready), 32'h0);
      check("rst_b_ready", 32'(b_ready), 32'h0);
      check("rst_c_ready", 32'(c_ready), 32'h0);
      check("rst_c_oval",  32'(c_oval),  32'h0);

      // Release; only A keeps its requests.
      rst_n   = 1'b1;
      b_valid = '0;
      c_valid = '0;
      settle();
      check("a_first_ready", 32'(a_ready), 32'b0001);

      // Round-robin: 0,1,2,3,0 back to back.
      for (int k = 0; k < 5; k++) begin
         tick();
         check("rr_oval",  32'(a_oval),  32'h1);
         check("rr_osel",  32'(a_osel),  32'(k % 4));
         check("rr_odata", 32'(a_odata), 32'(8'hA0 + 8'(k % 4)));
      end
      a_valid = '0;
      tick();
      check("drain_oval",  32'(a_oval),  32'h0);
      check("drain_odata", 32'(a_odata), 32'hA0);

      // Backpressure on a held 55; ptr is 1 so channel 1 wins.
      a_data  = 32'h00005500;
      a_valid = 4'b0010;
      tick();
      check("bp_load_oval",  32'(a_oval),  32'h1);
      check("bp_load_odata", 32'(a_odata), 32'h55);
      a_ordy = 1'b0;
      a_data = 32'h00006600;
      settle();
      check("bp_ready0", 32'(a_ready), 32'h0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("bp_hold_oval",  32'(a_oval),  32'h1);
         check("bp_hold_odata", 32'(a_odata), 32'h55);
         check("bp_hold_ready", 32'(a_ready), 32'h0);
      end
      a_ordy = 1'b1;
      settle();
      check("bp_release_ready", 32'(a_ready), 32'b0010);
      tick();
      check("bp_next_oval",  32'(a_oval),  32'h1);
      check("bp_next_odata", 32'(a_odata), 32'h66);
      a_valid = '0;
      tick();

      // Forced select of channel 2 with everything valid (ptr is now 2).
      a_data  = 32'hA3A2A1A0;
      a_valid = 4'b1111;
      a_fen   = 1'b1;
      a_fsel  = 3'd2;
      settle();
      check("frc_ready", 32'(a_ready), 32'b0100);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("frc_osel",  32'(a_osel),  32'h2);
         check("frc_odata", 32'(a_odata), 32'hA2);
         check("frc_ready_loop", 32'(a_ready), 32'b0100);
      end
      // Out-of-range forced index: nothing is eligible.
      a_fsel = 3'd5;
      settle();
      check("frc5_ready", 32'(a_ready), 32'h0);
      tick();
      check("frc5_oval", 32'(a_oval), 32'h0);
      tick();
      check("frc5_oval2",  32'(a_oval),  32'h0);
      check("frc5_ready2", 32'(a_ready), 32'h0);
      // Forced transfers leave ptr at 2.
      a_fen = 1'b0;
      settle();
      check("frc_ptr_kept", 32'(a_ready), 32'b0100);
      a_valid = '0;
      tick();

      // Fixed priority: channel 1 beats channel 3 every cycle.
      b_valid = 4'b1010;
      settle();
      check("fp_ready", 32'(b_ready), 32'b0010);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("fp_osel",  32'(b_osel),  32'h1);
         check("fp_odata", 32'(b_odata), 32'hB1);
         check("fp_ready_loop", 32'(b_ready), 32'b0010);
      end
      b_valid = 4'b1000;
      settle();
      check("fp_ch3_ready", 32'(b_ready), 32'b1000);
      tick();
      check("fp_ch3_osel", 32'(b_osel), 32'h3);
      b_valid = '0;
      tick();

      // N=3 wrap: 0,1,2,0 then sparse requests.
      c_valid = 3'b111;
      settle();
      check("n3_ready", 32'(c_ready), 32'b001);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("n3_osel",  32'(c_osel),  32'(k % 3));
         check("n3_odata", 32'(c_odata), 32'(8'hC0 + 8'(k % 3)));
      end
      c_valid = 3'b100;
      settle();
      check("n3_sparse_ready", 32'(c_ready), 32'b100);
      tick();
      check("n3_sparse_osel2", 32'(c_osel), 32'h2);
      c_valid = 3'b011;
      settle();
      check("n3_wrap_ready", 32'(c_ready), 32'b001);
      tick();
      check("n3_sparse_osel0", 32'(c_osel), 32'h0);
      check("n3_next_ready",   32'(c_ready), 32'b010);
      tick();
      check("n3_sparse_osel1", 32'(c_osel), 32'h1);
      c_valid = '0;
      tick();

      // Reset while a word is stalled discards it and clears ptr.
      a_data  = 32'h00007700;
      a_valid = 4'b0010;
      a_ordy  = 1'b0;
      tick();
      check("mid_load_oval", 32'(a_oval), 32'h1);
      a_valid = '0;
      rst_n   = 1'b0;
      tick();
      check("mid_rst_oval",  32'(a_oval),  32'h0);
      check("mid_rst_odata", 32'(a_odata), 32'h00);
      check("mid_rst_osel",  32'(a_osel),  32'h0);
      rst_n   = 1'b1;
      a_ordy  = 1'b1;
      a_valid = 4'b1111;
      settle();
      check("mid_rst_ptr", 32'(a_ready), 32'b0001);
      a_valid = '0;
      tick();
      check("mid_rst_nodeliver", 32'(a_oval), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
